// File: rtl/adc_arb_pkg.sv
// adc_arbiter shared types and defaults.
// Width of the ADC sample, FSM states, default timing constants.
package adc_arb_pkg;

  localparam int ADC_W              = 10;
  localparam int GAP_CYCLES_DEF     = 1;
  localparam int TIMEOUT_CYCLES_DEF = 1023;
  localparam int TMO_W              = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    GAP
  } arb_state_t;

endpackage

// File: rtl/adc_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Searches req from last+1 with wrap-around; one-hot grant plus index.
module rr_pick #(
  parameter int N  = 4,
  parameter int LW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [LW-1:0] idx
);

  logic          found;
  logic [LW-1:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 1; i <= N; i++) begin
      pos = LW'((int'(last) + i) % N);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/adc_arbiter.sv
// adc_arbiter: round-robin owner of the ADC_Comm interface.
// Define ADC_ARB_TIMEOUT_EN to bound the wait for VALID_BYTE.
module adc_arbiter
  import adc_arb_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_REQ-1:0] REQ,
  output logic [N_REQ-1:0] GRANT,
  output logic [N_REQ-1:0] DONE,
  output logic [ADC_W-1:0] DATA_OUT,
  output logic             ERR,
  output logic             BUSY,
  output logic             START_COMM,
  input  logic             VALID_BYTE,
  input  logic [ADC_W-1:0] BYTE_IN
);

  localparam int LW = $clog2(N_REQ);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [ADC_W-1:0] data_q, data_d;
  logic             busy_q, busy_d;
  logic             start_q, start_d;
  logic [LW-1:0]    last_q, last_d;
  logic [7:0]       gap_q, gap_d;
  logic [N_REQ-1:0] pick_grant;
  logic [LW-1:0]    pick_idx;
`ifdef ADC_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] wcnt_q, wcnt_d;
  logic             err_q, err_d;
`endif

  rr_pick #(
    .N  (N_REQ),
    .LW (LW)
  ) u_pick (
    .req   (REQ),
    .last  (last_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    data_d  = data_q;
    start_d = 1'b0;
    last_d  = last_q;
    gap_d   = gap_q;
`ifdef ADC_ARB_TIMEOUT_EN
    wcnt_d  = wcnt_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (|REQ) begin
          grant_d = pick_grant;
          last_d  = pick_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        start_d = 1'b1;
        state_d = WAIT;
`ifdef ADC_ARB_TIMEOUT_EN
        wcnt_d  = '0;
`endif
      end
      WAIT: begin
        // A sample arriving on the timeout cycle still wins.
        if (VALID_BYTE) begin
          data_d  = BYTE_IN;
          done_d  = grant_q;
          grant_d = '0;
          gap_d   = '0;
          state_d = GAP;
        end
`ifdef ADC_ARB_TIMEOUT_EN
        else if (wcnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          done_d  = grant_q;
          err_d   = 1'b1;
          grant_d = '0;
          gap_d   = '0;
          state_d = GAP;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
`endif
      end
      GAP: begin
        if (gap_q == 8'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      last_q  <= LW'(N_REQ - 1);
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
    end
  end

`ifdef ADC_ARB_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      err_q  <= err_d;
    end
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  assign GRANT      = grant_q;
  assign DONE       = done_q;
  assign DATA_OUT   = data_q;
  assign BUSY       = busy_q;
  assign START_COMM = start_q;

endmodule

// File: tb/tb_adc_arbiter.sv
// Directed bench for adc_arbiter; the bench plays the ADC_Comm side.
// Timeout scenario runs only when ADC_ARB_TIMEOUT_EN is defined.
module tb_adc_arbiter;
  import adc_arb_pkg::*;

  localparam int N   = 4;
  localparam int G   = 2;
  localparam int TMO = 50;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req   = '0;
  logic [3:0] grant;
  logic [3:0] done;
  logic [9:0] dout;
  logic       err;
  logic       busy;
  logic       start;
  logic       vb    = 1'b0;
  logic [9:0] bin   = '0;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  adc_arbiter #(
    .N_REQ          (N),
    .GAP_CYCLES     (G),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .REQ        (req),
    .GRANT      (grant),
    .DONE       (done),
    .DATA_OUT   (dout),
    .ERR        (err),
    .BUSY       (busy),
    .START_COMM (start),
    .VALID_BYTE (vb),
    .BYTE_IN    (bin)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Wait for START_COMM, answer lat cycles later, capture DONE/DATA_OUT.
  task automatic serve(input int lat, input logic [9:0] val,
                       output logic [3:0] dn, output logic [9:0] dat,
                       output int ts, output bit ok);
    ok = 1'b0; dn = '0; dat = '0; ts = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    ts = cyc;
    repeat (lat) @(negedge clk);
    vb = 1'b1; bin = val;
    @(negedge clk);
    vb = 1'b0;
    dn = done; dat = dout;
  endtask

  task automatic test_reset();
    bit saw_start, saw_busy;
    rst_n = 1'b0; req = '0; vb = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({grant, done} !== 8'h00) $display("FAIL reset_grant_done: got %b want 0", {grant, done});
    else n_pass++;
    n_chk++;
    if (dout !== 10'd0) $display("FAIL reset_data: got %0d want 0", dout);
    else n_pass++;
    n_chk++;
    if ({err, busy, start} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {err, busy, start});
    else n_pass++;
    rst_n = 1'b1;
    saw_start = 1'b0; saw_busy = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (start) saw_start = 1'b1;
      if (busy) saw_busy = 1'b1;
    end
    n_chk++;
    if (saw_start !== 1'b0) $display("FAIL idle_start: got %b want 0", saw_start);
    else n_pass++;
    n_chk++;
    if (saw_busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", saw_busy);
    else n_pass++;
  endtask

  task automatic test_single();
    int extra;
    req = 4'b0100;
    @(negedge clk);
    n_chk++;
    if ({grant, busy, start} !== {4'b0100, 1'b1, 1'b0})
      $display("FAIL single_issue: got %b/%b/%b want 0100/1/0", grant, busy, start);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (start !== 1'b1) $display("FAIL single_start: got %b want 1", start);
    else n_pass++;
    extra = 0;
    repeat (19) begin
      @(negedge clk);
      if (start) extra++;
    end
    vb = 1'b1; bin = 10'd512;
    @(negedge clk);
    vb = 1'b0;
    n_chk++;
    if (extra != 0) $display("FAIL single_one_pulse: got %0d extra want 0", extra);
    else n_pass++;
    n_chk++;
    if ({done, grant, err} !== {4'b0100, 4'b0000, 1'b0})
      $display("FAIL single_done: got %b/%b/%b want 0100/0000/0", done, grant, err);
    else n_pass++;
    n_chk++;
    if (dout !== 10'd512) $display("FAIL single_data: got %0d want 512", dout);
    else n_pass++;
    req = '0;
    @(negedge clk);
    n_chk++;
    if (done !== 4'b0000) $display("FAIL single_done_pulse: got %b want 0000", done);
    else n_pass++;
  endtask

  task automatic test_stray_valid();
    logic [3:0] dn;
    logic [9:0] dat, d0;
    int ts;
    bit ok;
    repeat (G + 2) @(negedge clk);
    d0 = dout;
    vb = 1'b1; bin = 10'd999;
    @(negedge clk);
    vb = 1'b0;
    n_chk++;
    if ({done, busy} !== 5'b0) $display("FAIL stray_idle_done: got %b/%b want 0000/0", done, busy);
    else n_pass++;
    n_chk++;
    if (dout !== d0) $display("FAIL stray_idle_data: got %0d want %0d", dout, d0);
    else n_pass++;
    req = 4'b0001;
    serve(3, 10'd77, dn, dat, ts, ok);
    req = '0;
    n_chk++;
    if (!ok || dn !== 4'b0001 || dat !== 10'd77)
      $display("FAIL stray_conv: got ok=%0d %b %0d want ok=1 0001 77", ok, dn, dat);
    else n_pass++;
    vb = 1'b1; bin = 10'd999;
    @(negedge clk);
    vb = 1'b0;
    n_chk++;
    if (done !== 4'b0000) $display("FAIL stray_gap_done: got %b want 0000", done);
    else n_pass++;
    n_chk++;
    if (dout !== 10'd77) $display("FAIL stray_gap_data: got %0d want 77", dout);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [3:0] dn;
    logic [9:0] dat;
    int ts;
    bit ok;
    repeat (G + 2) @(negedge clk);
    req = 4'b0010;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (start) begin
        ok = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!ok) $display("FAIL rstmid_start: got no START_COMM want pulse");
    else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({grant, busy, start, done} !== 10'b0)
      $display("FAIL rstmid_clear: got %b/%b/%b/%b want all 0", grant, busy, start, done);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (grant !== 4'b0010) $display("FAIL rstmid_regrant: got %b want 0010", grant);
    else n_pass++;
    serve(4, 10'd300, dn, dat, ts, ok);
    req = '0;
    n_chk++;
    if (!ok || dn !== 4'b0010 || dat !== 10'd300)
      $display("FAIL rstmid_conv: got ok=%0d %b %0d want ok=1 0010 300", ok, dn, dat);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [3:0] dn, exp_dn;
    logic [9:0] dat;
    int ts, ts_prev, lat_prev;
    bit ok;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1111;
    ts_prev = 0; lat_prev = 0;
    for (int k = 0; k < 5; k++) begin
      serve(5 + k, 10'(k + 1), dn, dat, ts, ok);
      exp_dn = 4'b0001 << (k % 4);
      n_chk++;
      if (!ok || dn !== exp_dn)
        $display("FAIL rr_order_%0d: got ok=%0d %b want %b", k, ok, dn, exp_dn);
      else n_pass++;
      n_chk++;
      if (dat !== 10'(k + 1)) $display("FAIL rr_data_%0d: got %0d want %0d", k, dat, k + 1);
      else n_pass++;
      if (k > 0) begin
        n_chk++;
        if (ts - ts_prev != lat_prev + G + 3)
          $display("FAIL rr_spacing_%0d: got %0d want %0d", k, ts - ts_prev, lat_prev + G + 3);
        else n_pass++;
      end
      ts_prev = ts; lat_prev = 5 + k;
    end
    req = '0;
  endtask

`ifdef ADC_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [3:0] dn;
    logic [9:0] dat, d0;
    int ts, cnt;
    bit ok;
    // last owner was 0 after the rotation test, so 1 is next in line.
    repeat (G + 2) @(negedge clk);
    d0 = dout;
    req = 4'b0110;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (start) begin
        ok = 1'b1;
        break;
      end
    end
    cnt = 0;
    for (int i = 0; i < 200 && ok; i++) begin
      @(negedge clk);
      cnt++;
      if (done != 4'b0000) break;
    end
    n_chk++;
    if (!ok || cnt != TMO) $display("FAIL tmo_latency: got ok=%0d %0d want 50", ok, cnt);
    else n_pass++;
    n_chk++;
    if ({done, err} !== {4'b0010, 1'b1}) $display("FAIL tmo_done_err: got %b/%b want 0010/1", done, err);
    else n_pass++;
    n_chk++;
    if (dout !== d0) $display("FAIL tmo_data: got %0d want %0d", dout, d0);
    else n_pass++;
    req = 4'b0100;
    serve(2, 10'd5, dn, dat, ts, ok);
    n_chk++;
    if (!ok || {dn, err} !== {4'b0100, 1'b0} || dat !== 10'd5)
      $display("FAIL tmo_next: got ok=%0d %b/%b %0d want 0100/0 5", ok, dn, err, dat);
    else n_pass++;
    req = '0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_stray_valid();
    test_reset_mid();
    test_round_robin();
`ifdef ADC_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/adc_arbiter.md
# adc_arbiter

Round-robin arbiter and sequencer that shares the single `ADC_Comm` serial ADC interface between up to `N_REQ` requesters (e.g. trip monitors, calibration, telemetry). It accepts level requests, grants one owner at a time, issues the one-cycle `Start_Comm` pulse, and captures the 10-bit result. It returns the result to the owner with a one-hot done pulse, then enforces an inter-conversion gap before the next grant. It sits between the `ADC_Comm` instance and all logic that needs ADC samples.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `GAP_CYCLES`, 1: idle cycles after each conversion before the next `START_COMM`, 1..255.
- `TIMEOUT_CYCLES`, 1023: maximum cycles waited for `VALID_BYTE`. Used only with `ADC_ARB_TIMEOUT_EN`.

Ports:
- `CLK`, in, 1: single clock. One clock; reset is asynchronous and active-low.
- `RST_N`, in, 1: asynchronous active-low reset.
- `REQ`, in, N_REQ: level request per requester, held until its `DONE` bit.
- `GRANT`, out, N_REQ: one-hot current owner; all zero when no owner.
- `DONE`, out, N_REQ: one-cycle one-hot completion pulse to the owner.
- `DATA_OUT`, out, 10: last captured sample; valid whenever any `DONE` bit is high.
- `ERR`, out, 1: high together with `DONE` when the conversion timed out.
- `BUSY`, out, 1: high in every state except IDLE.
- `START_COMM`, out, 1: to `ADC_Comm.Start_Comm`.
- `VALID_BYTE`, in, 1: from `ADC_Comm.Valid_Byte`.
- `BYTE_IN`, in, 10: from `ADC_Comm.BYTE_OUT`.

## Operation
- Reset values: state IDLE; `GRANT`, `DONE`, `ERR`, `BUSY`, and `START_COMM` are 0; `DATA_OUT` is 0; round-robin pointer `last` is `N_REQ-1`, so requester 0 has first priority. All outputs are registered.
- IDLE: if `REQ` is nonzero, pick the first set bit searching from `last+1` with wrap-around, set `GRANT` one-hot, update `last` to the winner, and go to ISSUE.
- ISSUE: `START_COMM` is 1 for exactly this cycle. Go to WAIT.
- WAIT: on `VALID_BYTE`=1, register `BYTE_IN` into `DATA_OUT`, pulse `DONE[owner]`, and go to GAP. `GRANT` clears in the same cycle `DONE` is high.
- GAP: count `GAP_CYCLES` cycles, then go to IDLE. `REQ` is not sampled in GAP.
- `VALID_BYTE` outside WAIT is ignored. `DATA_OUT` is unchanged and no `DONE` is issued.
- A requester dropping `REQ` after its grant does not abort the conversion. `DONE` still pulses.
- `REQ` dropped before it is sampled in IDLE is simply not granted.
- Simultaneous requests: strict rotation, with no requester granted twice while another is pending.
- Reset mid-conversion returns everything to reset values immediately. `ADC_Comm` shares `RST_N`, so no stale `VALID_BYTE` is expected.

## Timing
- `REQ` sampled high at edge k (state IDLE) gives `GRANT` and state ISSUE after edge k. `START_COMM` is high for one cycle from edge k+1 to edge k+2.
- `VALID_BYTE` sampled high at edge m (WAIT) gives `DONE`, new `DATA_OUT`, and GAP after edge m.
- A back-to-back request is granted no earlier than `GAP_CYCLES`+1 edges after `DONE`.
- Minimum `START_COMM` spacing is the conversion time + `GAP_CYCLES` + 3 cycles.

## Configuration
- `ADC_ARB_TIMEOUT_EN` defined:
  - A 10-bit-or-wider counter runs in WAIT, cleared on entry.
  - When it reaches `TIMEOUT_CYCLES` with no `VALID_BYTE`, pulse `DONE[owner]` with `ERR`=1, leave `DATA_OUT` unchanged, and go to GAP.
  - `VALID_BYTE` in the same cycle as the timeout wins: the sample is captured and `ERR`=0.
- Not defined: WAIT has no exit except `VALID_BYTE`, `ERR` is tied to 0, and no counter is synthesized.

## Structure
- Package `adc_arb_pkg`:
  - `ADC_W` = 10.
  - `arb_state_t` enum {IDLE, ISSUE, WAIT, GAP}.
  - Default `GAP_CYCLES` and `TIMEOUT_CYCLES` constants.
- Sub-module `rr_pick`: combinational round-robin picker with inputs `req[N]` and `last`, outputs a one-hot `grant` and its index, parameterized by N. It is reusable by other shared-resource arbiters.

## Test plan
- Reset with `REQ`=4'b0000: all outputs 0. Release reset and hold 10 cycles: `START_COMM` never rises and `BUSY`=0.
- Single request, `REQ[2]`=1, model returns 10'd512 after 20 cycles: `GRANT`=4'b0100, one `START_COMM` pulse, then `DONE`=4'b0100 with `DATA_OUT`=512.
- `REQ`=4'b1111 held, model returns 1, 2, 3, 4 in turn: `DONE` order is 0, 1, 2, 3, then 0 again. `START_COMM` spacing is at least conversion + `GAP_CYCLES` + 3.
- Stray `VALID_BYTE` during IDLE and during GAP with `BYTE_IN`=10'd999: `DATA_OUT` is unchanged and no `DONE` is issued.
- Assert `RST_N`=0 in WAIT, mid-conversion for owner 1: next cycle `GRANT`=0, `BUSY`=0, `START_COMM`=0. After release, a pending `REQ[1]` is granted first.
- With `ADC_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=50, model never answers: `DONE[owner]` and `ERR`=1 exactly 50 cycles after entering WAIT, `DATA_OUT` keeps its prior value, and the next owner is then served.
